alu_op_sched: RTL and testbench
===============================

ALU_OP_SCHED -- requirements
Module: alu_op_sched

Parameters
REQ-001 The block SHALL have parameter MUL_LAT, default 4, giving the cycles from mul_en pulse to a valid alu_result for a multiply (legal range 1..15).
REQ-002 The block SHALL have parameter ADD_LAT, default 3, giving the cycles from add_en pulse to a valid alu_result for an add (legal range 1..15).

Interface
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports req0_valid and req1_valid, input, 1 bit each: requester N presents an operation.
REQ-006 The block SHALL have ports req0_ready and req1_ready, output, 1 bit each: the operation is accepted on a cycle where valid and ready are both high.
REQ-007 The block SHALL have ports req0_op and req1_op, input, 4 bits each: the op code, 4'b0010 for multiply and 4'b0100 for add.
REQ-008 The block SHALL have ports req0_in1, req0_in2, req1_in1 and req1_in2, input, 32 bits each: IEEE-754 single-precision operands.
REQ-009 The block SHALL have port alu_control, output, 4 bits: op code to the ALU.
REQ-010 The block SHALL have ports alu_in1 and alu_in2, output, 32 bits each: operands to the ALU.
REQ-011 The block SHALL have ports mul_en and add_en, output, 1 bit each: one-cycle start strobes to the ALU.
REQ-012 The block SHALL have port alu_result, input, 32 bits: the ALU result.
REQ-013 The block SHALL have ports rsp_valid (output, 1 bit), rsp_ready (input, 1 bit), rsp_id (output, 1 bit, requester index), rsp_data (output, 32 bits), rsp_zero (output, 1 bit, high when rsp_data==0) and rsp_err (output, 1 bit, illegal op).

Function
REQ-014 The block SHALL implement FSM states IDLE, ISSUE, WAIT and RESP, with one operation in flight at most.
REQ-015 In IDLE, the block SHALL grant exactly one valid requester; if both are valid, it SHALL grant the one not granted last (round-robin), and requester 0 SHALL win the first contention after reset.
REQ-016 reqN_ready SHALL be combinational and high only in IDLE for the granted requester; both ready signals SHALL be low in all other states.
REQ-017 On handshake the block SHALL capture op, operands and id, then go to ISSUE if the op is legal.
REQ-018 On handshake with an illegal op, the block SHALL go directly to RESP with rsp_err=1, rsp_data=0 and rsp_zero=1, and SHALL drive no ALU strobe.
REQ-019 ISSUE SHALL last one cycle: the block SHALL drive alu_control, alu_in1 and alu_in2 from the captured values, pulse exactly one strobe (mul_en for 0010, add_en for 0100), and load the 4-bit counter with LAT-1.
REQ-020 alu_control, alu_in1 and alu_in2 SHALL stay stable from ISSUE through the last WAIT cycle, and SHALL be 0 in IDLE and RESP.
REQ-021 WAIT SHALL last exactly LAT cycles; on the last WAIT cycle (counter==0) the block SHALL register alu_result into rsp_data, set rsp_zero and go to RESP.
REQ-022 Latency: handshake in cycle k SHALL give rsp_valid high in cycle k+LAT+2.
REQ-023 In RESP, rsp_valid SHALL be high and rsp_* SHALL be stable until rsp_ready=1; on that edge the block SHALL go to IDLE and update the round-robin pointer.
REQ-024 The block SHALL accept a new request no earlier than the cycle after the RESP handshake, so back-to-back operations have a spacing of LAT+3 cycles minimum when rsp_ready is held high.
REQ-025 A change in reqN_valid while the block is not in IDLE SHALL have no effect, and requesters SHALL hold their valid signal until ready.

Reset
REQ-026 rst=0 SHALL immediately force state IDLE, round-robin pointer to requester 0, counter=0, and all outputs to 0 (rsp_zero=0, strobes low).
REQ-027 Assertion of rst during ISSUE, WAIT or RESP SHALL abort the operation with no response produced, and a late alu_result SHALL be ignored.
REQ-028 After rst deasserts, the first rising edge SHALL be able to accept a request.

Verification
REQ-029 req0 multiply 0x40000000 x 0x40400000, ALU model with MUL_LAT=4 -> mul_en one pulse in cycle k+1; rsp_valid in cycle k+6 with rsp_data=0x40C00000, rsp_id=0, rsp_zero=0, rsp_err=0.
REQ-030 req1 add 0x3FC00000 + 0x40200000 with ADD_LAT=3 -> add_en one pulse; rsp_valid at k+5, rsp_data=0x40800000, rsp_id=1.
REQ-031 Both requesters valid continuously with rsp_ready=1 for 4 operations -> grants in order 0,1,0,1, and no ready is high outside IDLE.
REQ-032 req0_op=4'b1000 -> no strobe; rsp_valid at k+1 with rsp_err=1, rsp_data=0, rsp_zero=1.
REQ-033 Add 0x3F800000 + 0xBF800000 with rsp_ready held low for 5 cycles -> rsp_zero=1 and rsp_* stable for all 5 cycles; IDLE one cycle after rsp_ready rises.
REQ-034 rst pulsed low during WAIT -> all outputs 0 immediately, no rsp_valid afterwards, and the next request completes normally.

Source files
------------

// File: rtl/alu_op_sched.sv
// Two-requester front end for a floating-point ALU with fixed multiply/add latency.
// Round-robin grants one operation at a time, times the ALU latency and returns a response.
module alu_op_sched #(
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned ADD_LAT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [3:0]  req0_op,
  input  logic [3:0]  req1_op,
  input  logic [31:0] req0_in1,
  input  logic [31:0] req0_in2,
  input  logic [31:0] req1_in1,
  input  logic [31:0] req1_in2,
  output logic [3:0]  alu_control,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  output logic        mul_en,
  output logic        add_en,
  input  logic [31:0] alu_result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_data,
  output logic        rsp_zero,
  output logic        rsp_err
);

  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0100;
  localparam logic [3:0] MUL_CNT = 4'(MUL_LAT - 1);
  localparam logic [3:0] ADD_CNT = 4'(ADD_LAT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT, ST_RESP} state_t;

  state_t      state;
  logic        rr_ptr;    // requester that wins the next contention
  logic        id_q;
  logic [3:0]  cnt;

  logic        any_valid;
  logic        grant_id;
  logic        hs;
  logic        sel_legal;
  logic [3:0]  sel_op;
  logic [31:0] sel_in1;
  logic [31:0] sel_in2;

  assign any_valid  = req0_valid | req1_valid;
  assign grant_id   = (req0_valid & req1_valid) ? rr_ptr : ~req0_valid;
  assign req0_ready = (state == ST_IDLE) & any_valid & ~grant_id;
  assign req1_ready = (state == ST_IDLE) & any_valid &  grant_id;
  assign hs         = (state == ST_IDLE) & any_valid;

  assign sel_op    = grant_id ? req1_op  : req0_op;
  assign sel_in1   = grant_id ? req1_in1 : req0_in1;
  assign sel_in2   = grant_id ? req1_in2 : req0_in2;
  assign sel_legal = (sel_op == OP_MUL) | (sel_op == OP_ADD);

  // NOTE: every register here is assigned with <= so all updates land together at the
  // edge; mixing in blocking assignments would make results depend on statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= 1'b0;
      id_q        <= 1'b0;
      cnt         <= '0;
      alu_control <= '0;
      alu_in1     <= '0;
      alu_in2     <= '0;
      mul_en      <= 1'b0;
      add_en      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= 1'b0;
      rsp_data    <= '0;
      rsp_zero    <= 1'b0;
      rsp_err     <= 1'b0;
    end else begin
      mul_en <= 1'b0;
      add_en <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (hs) begin
            id_q <= grant_id;
            if (sel_legal) begin
              alu_control <= sel_op;
              alu_in1     <= sel_in1;
              alu_in2     <= sel_in2;
              mul_en      <= (sel_op == OP_MUL);
              add_en      <= (sel_op == OP_ADD);
              state       <= ST_ISSUE;
            end else begin
              // Illegal op never reaches the ALU; answer with an error straight away.
              rsp_valid <= 1'b1;
              rsp_id    <= grant_id;
              rsp_data  <= '0;
              rsp_zero  <= 1'b1;
              rsp_err   <= 1'b1;
              state     <= ST_RESP;
            end
          end
        end
        ST_ISSUE: begin
          cnt   <= (alu_control == OP_MUL) ? MUL_CNT : ADD_CNT;
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            rsp_valid   <= 1'b1;
            rsp_id      <= id_q;
            rsp_data    <= alu_result;
            rsp_zero    <= (alu_result == 32'd0);
            rsp_err     <= 1'b0;
            alu_control <= '0;
            alu_in1     <= '0;
            alu_in2     <= '0;
            state       <= ST_RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_id    <= 1'b0;
            rsp_data  <= '0;
            rsp_zero  <= 1'b0;
            rsp_err   <= 1'b0;
            rr_ptr    <= ~id_q;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sched.sv
// Directed bench for alu_op_sched with a fixed-latency ALU model that only presents
// a valid result on the exact cycle the latency allows.
module tb_alu_op_sched;

  localparam int MUL_LAT = 4;
  localparam int ADD_LAT = 3;
  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0100;
  localparam logic [3:0] OP_BAD = 4'b1000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op = '0, req1_op = '0;
  logic [31:0] req0_in1 = '0, req0_in2 = '0, req1_in1 = '0, req1_in2 = '0;
  logic [3:0]  alu_control;
  logic [31:0] alu_in1, alu_in2;
  logic        mul_en, add_en;
  logic [31:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic        rsp_id;
  logic [31:0] rsp_data;
  logic        rsp_zero, rsp_err;

  int n_tests = 0;
  int n_fail  = 0;

  alu_op_sched #(.MUL_LAT(MUL_LAT), .ADD_LAT(ADD_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_in1(req0_in1), .req0_in2(req0_in2),
    .req1_in1(req1_in1), .req1_in2(req1_in2),
    .alu_control(alu_control), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .mul_en(mul_en), .add_en(add_en), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Hand-computed single-precision results for the operand pairs used below.
  function automatic logic [31:0] fp_model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op == OP_MUL && a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    if (op == OP_ADD && a == 32'h3FC0_0000 && b == 32'h4020_0000) return 32'h4080_0000;
    if (op == OP_ADD && a == 32'h3F80_0000 && b == 32'hBF80_0000) return 32'h0000_0000;
    return 32'hFFFF_FFFF;
  endfunction

  // ALU model: result is valid only in the LAT-th cycle after the strobe cycle.
  int          alu_cnt;
  logic [31:0] alu_res_q;
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      alu_cnt   <= 0;
      alu_res_q <= '0;
    end else if (mul_en) begin
      alu_cnt   <= MUL_LAT;
      alu_res_q <= fp_model(alu_control, alu_in1, alu_in2);
    end else if (add_en) begin
      alu_cnt   <= ADD_LAT;
      alu_res_q <= fp_model(alu_control, alu_in1, alu_in2);
    end else if (alu_cnt != 0) begin
      alu_cnt <= alu_cnt - 1;
    end
  end
  assign alu_result = (alu_cnt == 1) ? alu_res_q : 32'hA5A5_A5A5;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input bit id, input bit vld, input logic [3:0] op,
                           input logic [31:0] a, input logic [31:0] b);
    if (id) begin
      req1_valid = vld; req1_op = op; req1_in1 = a; req1_in2 = b;
    end else begin
      req0_valid = vld; req0_op = op; req0_in1 = a; req0_in2 = b;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctl"}, {rsp_valid, rsp_zero, rsp_err, rsp_id, mul_en, add_en, alu_control}, '0);
    check({tag, "_dat"}, {alu_in1, alu_in2}, '0);
    check({tag, "_rsp"}, rsp_data, '0);
  endtask

  // One complete operation from a single requester; hold = cycles rsp_ready stays low in RESP.
  task automatic run_op(input bit id, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int lat, input logic [31:0] exp_data, input bit exp_err, input int hold);
    logic legal;
    legal = (op == OP_MUL) || (op == OP_ADD);
    rsp_ready = (hold == 0);
    @(negedge clk);
    drive_req(id, 1'b1, op, a, b);
    #1 check("ready", {req1_ready, req0_ready}, id ? 2'b10 : 2'b01);
    @(negedge clk);
    drive_req(id, 1'b0, 4'd0, 32'd0, 32'd0);
    #1;
    if (legal) begin
      check("strobe", {mul_en, add_en}, {op == OP_MUL, op == OP_ADD});
      check("issue_ctl", {alu_control, alu_in1}, {op, a});
      check("issue_in2", alu_in2, b);
      for (int i = 0; i < lat; i++) begin
        @(negedge clk); #1;
        check("wait", {mul_en, add_en, rsp_valid, req0_ready, req1_ready, alu_control, alu_in1},
              {5'b0, op, a});
      end
      @(negedge clk); #1;
    end
    check("resp_ctl", {rsp_valid, rsp_id, rsp_err, rsp_zero}, {1'b1, id, exp_err, exp_data == 32'd0});
    check("resp_data", rsp_data, exp_data);
    check("resp_alu", {mul_en, add_en, alu_control, alu_in1, alu_in2}, '0);
    for (int j = 0; j < hold; j++) begin
      @(negedge clk); #1;
      check("resp_hold", {rsp_valid, rsp_id, rsp_err, rsp_zero, rsp_data},
            {1'b1, id, exp_err, exp_data == 32'd0, exp_data});
    end
    rsp_ready = 1'b1;
    @(negedge clk); #1;
    check("resp_done", rsp_valid, 1'b0);
  endtask

  initial begin
    int grants[$];
    int gcyc[$];
    int exp_gap;

    // Reset state
    repeat (2) @(negedge clk);
    #1 check_all_zero("reset");
    check("reset_rdy", {req0_ready, req1_ready}, 2'b00);
    rst = 1'b1;

    // Round-robin under continuous contention; req0 wins first after reset
    @(negedge clk);
    drive_req(1'b0, 1'b1, OP_MUL, 32'h4000_0000, 32'h4040_0000);
    drive_req(1'b1, 1'b1, OP_ADD, 32'h3FC0_0000, 32'h4020_0000);
    rsp_ready = 1'b1;
    for (int c = 0; c < 60 && grants.size() < 4; c++) begin
      if (c != 0) @(negedge clk);
      #1;
      if (rsp_valid || mul_en || add_en || alu_control != 4'd0)
        check("rr_busy_rdy", {req0_ready, req1_ready}, 2'b00);
      if (rsp_valid)
        check("rr_rsp_data", rsp_data, rsp_id ? 32'h4080_0000 : 32'h40C0_0000);
      if (req0_ready || req1_ready) begin
        grants.push_back(int'(req1_ready));
        gcyc.push_back(c);
      end
    end
    @(negedge clk);
    drive_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    repeat (10) @(negedge clk);
    check("rr_count", grants.size(), 4);
    for (int i = 0; i < grants.size(); i++) begin
      check($sformatf("rr_grant%0d", i), grants[i], i % 2);
      if (i > 0) begin
        exp_gap = (grants[i-1] == 0) ? MUL_LAT + 3 : ADD_LAT + 3;
        check($sformatf("rr_gap%0d", i), gcyc[i] - gcyc[i-1], exp_gap);
      end
    end

    // Directed single operations
    run_op(1'b0, OP_MUL, 32'h4000_0000, 32'h4040_0000, MUL_LAT, 32'h40C0_0000, 1'b0, 0);
    run_op(1'b1, OP_ADD, 32'h3FC0_0000, 32'h4020_0000, ADD_LAT, 32'h4080_0000, 1'b0, 0);
    run_op(1'b0, OP_BAD, 32'h4000_0000, 32'h4040_0000, 0,       32'h0000_0000, 1'b1, 0);
    run_op(1'b1, OP_ADD, 32'h3F80_0000, 32'hBF80_0000, ADD_LAT, 32'h0000_0000, 1'b0, 5);

    // Reset asserted mid-WAIT aborts the operation
    @(negedge clk);
    drive_req(1'b1, 1'b1, OP_ADD, 32'h3FC0_0000, 32'h4020_0000);
    @(negedge clk);
    drive_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check_all_zero("abort");
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < ADD_LAT + 4; i++) begin
      @(negedge clk); #1;
      check("abort_quiet", {rsp_valid, mul_en, add_en}, 3'b000);
    end
    drive_req(1'b0, 1'b1, OP_MUL, 32'h4000_0000, 32'h4040_0000);
    drive_req(1'b1, 1'b1, OP_ADD, 32'h3FC0_0000, 32'h4020_0000);
    #1 check("abort_rr", {req1_ready, req0_ready}, 2'b01);
    drive_req(1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
    drive_req(1'b1, 1'b0, 4'd0, 32'd0, 32'd0);
    run_op(1'b0, OP_MUL, 32'h4000_0000, 32'h4040_0000, MUL_LAT, 32'h40C0_0000, 1'b0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
